// File: rtl/fft_sched_pkg.sv
// Shared types and sizing helpers for the FFT frame scheduler.
// State encoding, channel-index width and frame-counter width.
package fft_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DRAIN = 3'd4
  } sched_state_e;

  // Channel index width; a single-channel build still needs one bit.
  function automatic int chw(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  function automatic int fft_points(input int logn);
    return 1 << logn;
  endfunction

  // Wide enough to hold the value N itself, not just N-1.
  function automatic int cnt_width(input int logn);
    return logn + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request searching upward
// from the channel after last_grant, wrapping modulo NCH.
module rr_arbiter
  import fft_sched_pkg::*;
#(
  parameter int NCH = 2,
  parameter int CHW = chw(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CHW-1:0] last_grant,
  output logic [NCH-1:0] gnt_oh,
  output logic [CHW-1:0] gnt_bin
);

  logic [CHW-1:0] idx_s;

  // Walk from farthest to nearest so the nearest requester overwrites last
  always_comb begin
    gnt_bin = {CHW{1'b0}};
    idx_s   = {CHW{1'b0}};
    for (int i = NCH; i >= 1; i--) begin
      idx_s   = CHW'((int'(last_grant) + i) % NCH);
      gnt_bin = req[idx_s] ? idx_s : gnt_bin;
    end
    gnt_oh = (|req) ? (NCH'(1'b1) << gnt_bin) : {NCH{1'b0}};
  end

endmodule

// File: rtl/fft_frame_scheduler.sv
// Time-shares one FFT engine between NCH frame streams: round-robin grant,
// load N samples, start, wait for done, drain N tagged results.
module fft_frame_scheduler
  import fft_sched_pkg::*;
#(
  parameter int LOGN       = 4,
  parameter int DATA_WIDTH = 16,
  parameter int NCH        = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NCH-1:0]            ch_valid,
  input  logic [NCH*DATA_WIDTH-1:0] ch_real,
  input  logic [NCH*DATA_WIDTH-1:0] ch_imag,
  output logic [NCH-1:0]            ch_ready,
  output logic [DATA_WIDTH-1:0]     f_s_real,
  output logic [DATA_WIDTH-1:0]     f_s_imag,
  output logic                      f_s_valid,
  input  logic                      f_s_ready,
  output logic                      f_start,
  input  logic                      f_busy,
  input  logic                      f_done,
  input  logic [DATA_WIDTH-1:0]     f_m_real,
  input  logic [DATA_WIDTH-1:0]     f_m_imag,
  input  logic                      f_m_valid,
  output logic                      f_m_ready,
  output logic [DATA_WIDTH-1:0]     out_real,
  output logic [DATA_WIDTH-1:0]     out_imag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [chw(NCH)-1:0]       out_ch,
  output logic                      out_last,
  output logic [chw(NCH)-1:0]       cur_ch,
  output logic [15:0]               frames_done,
  output logic                      err_timeout
);

  localparam int N   = fft_points(LOGN);
  localparam int CW  = cnt_width(LOGN);
  localparam int CHW = chw(NCH);
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  LAST_IDX = CW'(N - 1);
  localparam logic [TW-1:0]  TMO      = TW'(TIMEOUT);
  localparam logic [TW-1:0]  TMO_M1   = TW'(TIMEOUT - 1);
  localparam logic [CHW-1:0] MAX_CH   = CHW'(NCH - 1);

  sched_state_e   state_r, state_s;
  logic [CW-1:0]  s_cnt_r, r_cnt_r;
  logic [TW-1:0]  wait_cnt_r;
  logic [CHW-1:0] cur_ch_r, ptr_r, last_grant_s, gnt_bin_s;
  logic [NCH-1:0] gnt_oh_s;
  logic [15:0]    frames_done_r;
  logic           err_timeout_r, f_start_r;
  logic           any_req_s, load_hs_s, drain_hs_s;
  logic           unused_s;

  // Completion is taken from f_done alone; busy is informational only.
  assign unused_s = f_busy;

  // ptr_r is the next channel to be offered; the arbiter wants the one before it.
  assign last_grant_s = (ptr_r == {CHW{1'b0}}) ? MAX_CH : ptr_r - CHW'(1'b1);
  assign any_req_s    = |gnt_oh_s;

  rr_arbiter #(.NCH(NCH), .CHW(CHW)) u_arb (
    .req        (ch_valid),
    .last_grant (last_grant_s),
    .gnt_oh     (gnt_oh_s),
    .gnt_bin    (gnt_bin_s)
  );

  // Granted lane select toward the FFT input
  always_comb begin
    f_s_real = {DATA_WIDTH{1'b0}};
    f_s_imag = {DATA_WIDTH{1'b0}};
    for (int c = 0; c < NCH; c++) begin
      f_s_real = (cur_ch_r == CHW'(c)) ? ch_real[c*DATA_WIDTH +: DATA_WIDTH] : f_s_real;
      f_s_imag = (cur_ch_r == CHW'(c)) ? ch_imag[c*DATA_WIDTH +: DATA_WIDTH] : f_s_imag;
    end
  end

  // Next-state and handshake decode
  always_comb begin
    state_s    = state_r;
    ch_ready   = {NCH{1'b0}};
    f_s_valid  = 1'b0;
    f_m_ready  = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    load_hs_s  = 1'b0;
    drain_hs_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) state_s = ST_LOAD;
        else           state_s = ST_IDLE;
      end
      ST_LOAD: begin
        f_s_valid          = ch_valid[cur_ch_r];
        ch_ready[cur_ch_r] = f_s_ready;
        load_hs_s          = f_s_valid && f_s_ready;
        if (load_hs_s && (s_cnt_r == LAST_IDX)) state_s = ST_START;
        else                                    state_s = ST_LOAD;
      end
      ST_START: state_s = ST_WAIT;
      ST_WAIT: begin
        if (f_done) state_s = ST_DRAIN;
        else        state_s = ST_WAIT;
      end
      ST_DRAIN: begin
        out_valid  = f_m_valid;
        f_m_ready  = out_ready;
        drain_hs_s = f_m_valid && out_ready;
        out_last   = out_valid && (r_cnt_r == LAST_IDX);
        if (drain_hs_s && (r_cnt_r == LAST_IDX)) state_s = ST_IDLE;
        else                                     state_s = ST_DRAIN;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) state_r <= ST_IDLE;
    else       state_r <= state_s;
  end

  // Grant, counters, start pulse and status registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s_cnt_r       <= {CW{1'b0}};
      r_cnt_r       <= {CW{1'b0}};
      wait_cnt_r    <= {TW{1'b0}};
      cur_ch_r      <= {CHW{1'b0}};
      ptr_r         <= {CHW{1'b0}};
      frames_done_r <= 16'd0;
      err_timeout_r <= 1'b0;
      f_start_r     <= 1'b0;
    end else begin
      f_start_r <= load_hs_s && (s_cnt_r == LAST_IDX);
      case (state_r)
        ST_IDLE: begin
          s_cnt_r    <= {CW{1'b0}};
          r_cnt_r    <= {CW{1'b0}};
          wait_cnt_r <= {TW{1'b0}};
          if (any_req_s) cur_ch_r <= gnt_bin_s;
        end
        ST_LOAD: begin
          if (load_hs_s) s_cnt_r <= s_cnt_r + CW'(1'b1);
        end
        ST_WAIT: begin
          // Counter saturates at TIMEOUT so the error flag is raised once.
          if (f_done) begin
            wait_cnt_r <= {TW{1'b0}};
          end else if (wait_cnt_r != TMO) begin
            wait_cnt_r <= wait_cnt_r + TW'(1'b1);
            if (wait_cnt_r == TMO_M1) err_timeout_r <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_hs_s) begin
            if (r_cnt_r == LAST_IDX) begin
              r_cnt_r       <= {CW{1'b0}};
              frames_done_r <= frames_done_r + 16'd1;
              ptr_r         <= (cur_ch_r == MAX_CH) ? {CHW{1'b0}} : cur_ch_r + CHW'(1'b1);
            end else begin
              r_cnt_r <= r_cnt_r + CW'(1'b1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out_real    = f_m_real;
  assign out_imag    = f_m_imag;
  assign out_ch      = cur_ch_r;
  assign cur_ch      = cur_ch_r;
  assign frames_done = frames_done_r;
  assign err_timeout = err_timeout_r;
  assign f_start     = f_start_r;

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Bench for fft_frame_scheduler: channel sources, a behavioural FFT stub that
// echoes samples with inverted real part, and a result scoreboard.
module tb_fft_frame_scheduler;

  localparam int N = 16, DW = 16, NCH = 2, TMO = 32, DONE_DLY = 4;

  logic clk = 1'b0;
  logic rstn;
  logic [NCH-1:0] ch_valid, ch_ready;
  logic [NCH*DW-1:0] ch_real, ch_imag;
  logic [DW-1:0] f_s_real, f_s_imag, f_m_real, f_m_imag, out_real, out_imag;
  logic f_s_valid, f_s_ready, f_start, f_busy, f_done, f_m_valid, f_m_ready;
  logic out_valid, out_ready, out_last, err_timeout;
  logic [0:0] out_ch, cur_ch;
  logic [15:0] frames_done;

  always #5 clk = ~clk;

  fft_frame_scheduler #(.LOGN(4), .DATA_WIDTH(DW), .NCH(NCH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn), .ch_valid(ch_valid), .ch_real(ch_real), .ch_imag(ch_imag),
    .ch_ready(ch_ready), .f_s_real(f_s_real), .f_s_imag(f_s_imag), .f_s_valid(f_s_valid),
    .f_s_ready(f_s_ready), .f_start(f_start), .f_busy(f_busy), .f_done(f_done),
    .f_m_real(f_m_real), .f_m_imag(f_m_imag), .f_m_valid(f_m_valid), .f_m_ready(f_m_ready),
    .out_real(out_real), .out_imag(out_imag), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .out_last(out_last), .cur_ch(cur_ch), .frames_done(frames_done),
    .err_timeout(err_timeout)
  );

  typedef struct {
    int q0; int q1; bit stall; bit tog; bit plain; int exp_frames; logic [3:0] exp_ord;
  } vec_t;
  vec_t vecs[5];

  int n_checks = 0, n_fail = 0;
  logic [33:0] sb_q[$];
  int k[NCH], frm[NCH], quota[NCH];
  int stall_cnt, st, scnt, sn, sk, starts, viol, nord;
  bit stall_en, plain, toggle_en, never_done, tog, prev_start, err_smp, start_smp;
  logic [3:0] ord;
  logic [15:0] sre[N], sim[N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sample(input int c, input int f, input int kk);
    logic [15:0] re, im;
    if (plain) begin
      re = 16'(kk);
      im = 16'd0;
    end else begin
      re = {4'(c + 1), 4'(f), 8'(kk)};
      im = {8'(kk * 7), 4'(c), 4'(f)};
    end
    return {re, im};
  endfunction

  task automatic clear_model();
    sb_q.delete();
    for (int c = 0; c < NCH; c++) begin k[c] = 0; frm[c] = 0; end
    stall_cnt = 0; st = 0; scnt = 0; sn = 0; sk = 0; starts = 0; viol = 0;
    nord = 0; ord = 4'b0000; prev_start = 1'b0; tog = 1'b1; never_done = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ch_ready"}, ch_ready, 2'b00);
    check({tag, "_f_s_valid"}, f_s_valid, 1'b0);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_f_m_ready"}, f_m_ready, 1'b0);
    check({tag, "_f_start"}, f_start, 1'b0);
    check({tag, "_frames_done"}, frames_done, 16'd0);
    check({tag, "_err_timeout"}, err_timeout, 1'b0);
    check({tag, "_cur_ch"}, cur_ch, 1'b0);
  endtask

  task automatic do_reset(input bit chk, input string tag);
    rstn = 1'b0; ch_valid = '0; f_s_ready = 1'b0; f_done = 1'b0;
    f_m_valid = 1'b0; out_ready = 1'b0;
    clear_model();
    @(posedge clk); #1;
    if (chk) check_idle(tag);
    rstn = 1'b1;
  endtask

  // One clock of source, FFT stub and scoreboard activity.
  task automatic run_cycle();
    logic [31:0] smp;
    for (int c = 0; c < NCH; c++) begin
      ch_valid[c] = (frm[c] < quota[c]) && !(c == 0 && stall_cnt > 0);
      smp = sample(c, frm[c], k[c]);
      ch_real[c*DW +: DW] = smp[31:16];
      ch_imag[c*DW +: DW] = smp[15:0];
    end
    f_s_ready = (st == 0);
    f_done    = (st == 1) && (scnt == DONE_DLY) && !never_done;
    f_m_valid = (st == 2);
    f_m_real  = (st == 2) ? ~sre[sk] : 16'd0;
    f_m_imag  = (st == 2) ? sim[sk] : 16'd0;
    out_ready = toggle_en ? tog : 1'b1;
    #1;
    err_smp = err_timeout;
    start_smp = f_start;
    if ($countones(ch_ready) > 1) viol++;
    for (int c = 0; c < NCH; c++)
      for (int o = 0; o < NCH; o++)
        if (o != c && k[c] > 0 && ch_ready[o]) viol++;
    if (st == 2 && f_m_ready !== out_ready) viol++;
    if (out_last && !out_valid) viol++;
    if (f_start && prev_start) viol++;
    prev_start = f_start;
    if (stall_cnt > 0) stall_cnt--;
    for (int c = 0; c < NCH; c++) begin
      if (ch_valid[c] && ch_ready[c]) begin
        smp = sample(c, frm[c], k[c]);
        sb_q.push_back({1'(c), ~smp[31:16], smp[15:0], (k[c] == N - 1)});
        if (stall_en && c == 0 && frm[0] == 0 && k[0] == 7) stall_cnt = 5;
        k[c]++;
        if (k[c] == N) begin k[c] = 0; frm[c]++; end
      end
    end
    if (st == 0 && f_s_valid && f_s_ready) begin
      if (sn < N) begin sre[sn] = f_s_real; sim[sn] = f_s_imag; end
      sn++;
    end
    if (f_start) begin
      if (sn != N || st != 0) viol++;
      starts++; st = 1; scnt = 0;
    end else if (st == 1) begin
      if (f_done) begin st = 2; sk = 0; end
      else scnt++;
    end else if (st == 2 && f_m_valid && f_m_ready) begin
      sk++;
      if (sk == N) begin st = 0; sn = 0; end
    end
    if (out_valid && out_ready) begin
      check("sb_nonempty", sb_q.size() > 0, 1'b1);
      if (sb_q.size() > 0) check("result", {out_ch, out_real, out_imag, out_last}, sb_q.pop_front());
      if (out_last && nord < 4) begin ord[nord] = out_ch; nord++; end
    end
    if (toggle_en) tog = ~tog;
    @(posedge clk); #1;
  endtask

  task automatic run_to_frames(input int exp_frames);
    for (int cyc = 0; cyc < 3000 && !(frames_done == 16'(exp_frames) && sb_q.size() == 0); cyc++)
      run_cycle();
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    do_reset(1'b0, tag);
    quota[0] = v.q0; quota[1] = v.q1;
    stall_en = v.stall; toggle_en = v.tog; plain = v.plain;
    run_to_frames(v.exp_frames);
    check({tag, "_frames_done"}, frames_done, 16'(v.exp_frames));
    check({tag, "_grant_order"}, ord, v.exp_ord);
    check({tag, "_start_pulses"}, starts, v.exp_frames);
    check({tag, "_violations"}, viol, 0);
    check({tag, "_sb_left"}, sb_q.size(), 0);
  endtask

  initial begin
    vecs[0] = '{1, 0, 1'b0, 1'b0, 1'b1, 1, 4'b0000};
    vecs[1] = '{2, 2, 1'b0, 1'b0, 1'b0, 4, 4'b1010};
    vecs[2] = '{1, 1, 1'b1, 1'b0, 1'b0, 2, 4'b0010};
    vecs[3] = '{0, 1, 1'b0, 1'b1, 1'b0, 1, 4'b0001};
    vecs[4] = '{3, 1, 1'b0, 1'b0, 1'b0, 4, 4'b0010};
    ch_real = '0; ch_imag = '0; f_m_real = '0; f_m_imag = '0; f_busy = 1'b0;
    quota[0] = 0; quota[1] = 0;
    stall_en = 1'b0; toggle_en = 1'b0; plain = 1'b0;
    do_reset(1'b0, "por0");
    do_reset(1'b1, "por");

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Engine never completes: err_timeout rises 32 cycles into WAIT and sticks.
    stall_en = 1'b0; toggle_en = 1'b0; plain = 1'b0;
    do_reset(1'b0, "to");
    quota[0] = 1; quota[1] = 0; never_done = 1'b1;
    start_smp = 1'b0;
    for (int cyc = 0; cyc < 200 && !start_smp; cyc++) run_cycle();
    check("to_start_seen", start_smp, 1'b1);
    for (int j = 1; j <= 40; j++) begin
      run_cycle();
      if (j == 32) check("to_err_before", err_smp, 1'b0);
      if (j == 33) check("to_err_at_32", err_smp, 1'b1);
      if (j == 40) check("to_err_sticky", err_smp, 1'b1);
    end
    check("to_no_output", out_valid, 1'b0);
    do_reset(1'b1, "to_rst");

    // Reset in the middle of a load; the following frame must complete cleanly.
    quota[0] = 1; quota[1] = 0;
    for (int cyc = 0; cyc < 100 && k[0] != 9; cyc++) run_cycle();
    check("mid_reached_s9", k[0], 9);
    do_reset(1'b1, "mid_rst");
    quota[0] = 1; quota[1] = 0;
    run_to_frames(1);
    check("mid_frames_done", frames_done, 16'd1);
    check("mid_start_pulses", starts, 1);
    check("mid_violations", viol, 0);
    check("mid_sb_left", sb_q.size(), 0);
    check("mid_grant", ord[0], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
